infix_to_postfix: RTL and testbench
===================================

Name: infix_to_postfix

Overview:
- Front end of the expression calculator.
- Accepts an ASCII infix expression one character at a time and converts it to postfix using shunting-yard with an internal operator stack.
- Drives the calculator's token interface: INPUT_NUMBER/NUMBER_STB and INPUT_SIGN/SIGN_STB, throttled by the calculator's BUSY.
- Marks end of expression by pulsing both strobes in the same cycle.

Parameters:
- DEPTH, 16, operator stack entries (operators and '('), minimum 2.
- LVL_W, $clog2(DEPTH)+1, width of OP_LEVEL.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  asynchronous reset, active-high.
- IN_CHAR  input  8  ASCII character.
- IN_STB  input  1  IN_CHAR valid.
- IN_RDY  output  1  block can consume a character this cycle.
- INPUT_NUMBER  output  8  postfix operand.
- NUMBER_STB  output  1  one-cycle operand strobe.
- INPUT_SIGN  output  8  postfix operator ASCII ('+','-','*','/', '=' on end).
- SIGN_STB  output  1  one-cycle operator strobe.
- DS_BUSY  input  1  downstream BUSY; no new strobe while high.
- DONE  output  1  one-cycle pulse with end marker.
- ERR  output  1  sticky syntax/overflow error.
- OP_LEVEL  output  LVL_W  current operator stack occupancy.

Behaviour:
- Reset values (asynchronous, applied immediately when RST rises):
  - Outputs: all strobes, DONE, ERR, INPUT_NUMBER, INPUT_SIGN, OP_LEVEL = 0; IN_RDY = 1 once RST deasserts.
  - Internal: stack empty, accumulator 0, state ACCEPT.
- States: ACCEPT, EMIT_NUM, POP_OP, PUSH_OP, CLOSE, DRAIN, EMIT_END, FAULT.
- Character transfer: a character is consumed when IN_STB && IN_RDY. IN_RDY = 1 only in ACCEPT.
- ACCEPT, by character class:
  - Digit: acc <= (acc*10 + digit) mod 256; have_num <= 1; stay in ACCEPT.
  - Space: ignored.
  - '+', '-', '*', '/', '(', ')', '=': latch the token. If have_num, go to EMIT_NUM first; otherwise dispatch the token directly.
  - '(' after a digit: numbers are emitted before '(' is processed. Not an error.
  - Any other character: go to FAULT.
- EMIT_NUM: INPUT_NUMBER <= acc; NUMBER_STB pulses; acc and have_num cleared; then dispatch the latched token.
- Operator dispatch (POP_OP / PUSH_OP):
  - Precedence: '*' '/' = 2; '+' '-' = 1. All operators are left-associative.
  - While top of stack is an operator with precedence >= the new token's: pop it and emit it on INPUT_SIGN/SIGN_STB, one per emission slot.
  - Then push the new token and return to ACCEPT.
  - Push when OP_LEVEL == DEPTH: go to FAULT.
- '(': push; FAULT if full.
- ')' (CLOSE): pop and emit operators until '(' is found; discard the '('. Stack empties without finding '(': FAULT.
- '=' (DRAIN): pop and emit all remaining operators; any '(' found: FAULT. Then EMIT_END.
- EMIT_END: NUMBER_STB and SIGN_STB both high for one cycle, INPUT_SIGN = '=', INPUT_NUMBER = 0, DONE = 1. Then return to ACCEPT, ready for the next expression.
- Emission rule (applies to every strobe):
  - A strobe may assert only in a cycle where DS_BUSY = 0 and no strobe was asserted in the previous cycle.
  - Each strobe lasts exactly one cycle. Strobes never occur on consecutive cycles.
  - Output data is held stable until the next strobe.
  - While waiting on DS_BUSY, all state is frozen.
- Unary minus is not supported; '-' is always binary.
- Empty expression ("="): end marker only.
- FAULT:
  - ERR = 1, IN_RDY = 0, no strobes. Held until RST.
  - Stack contents are don't-care; OP_LEVEL frozen.
- Reset mid-emission: strobes drop asynchronously with RST; a partial expression is discarded.

Test Plan:
- "3+4=" with DS_BUSY low → NUMBER 3, NUMBER 4, SIGN '+', then both strobes with '=' and DONE. Gaps of at least 1 cycle between strobes.
- "2+3*4=" → 2, 3, 4, '*', '+', end. "8-2-1=" → 8, 2, '-', 1, '-', end (left associativity).
- "12*(3-1)=" → 12, 3, 1, '-', '*', end; OP_LEVEL peaks at 3. "300=" → NUMBER 44 (mod 256), end.
- DS_BUSY held high 10 cycles after the first strobe of "3+4=" → no strobe and IN_RDY low during the stall; emission resumes the first cycle DS_BUSY falls; token order unchanged.
- Errors, each from reset:
  - "3)" → ERR high after ')', no SIGN_STB.
  - "(3+4=" → emits 3, 4, '+', then ERR; no end marker.
  - "3#" → ERR.
  - DEPTH+1 '(' characters → ERR on the (DEPTH+1)th; OP_LEVEL = DEPTH.
- Assert RST asynchronously in the same cycle as a NUMBER_STB → strobe low immediately. After release: ERR = 0, OP_LEVEL = 0, IN_RDY = 1. "5=" then yields 5, end.

Source files
------------

// File: rtl/infix_to_postfix.sv
// Infix-to-postfix front end for the expression calculator.
// ASCII characters arrive one per IN_STB/IN_RDY handshake and are converted
// with shunting-yard into operand and operator strobes for the calculator.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_ACCEPT   | ready for a character; digits accumulate into acc_q
// S_EMIT_NUM | emit the accumulated operand, then dispatch the latched token
// S_POP_OP   | pop/emit operators of precedence >= the latched operator
// S_PUSH_OP  | push latched operator or '(' onto the stack
// S_CLOSE    | ')' : pop/emit until '(' and discard it
// S_DRAIN    | '=' : pop/emit everything left on the stack
// S_EMIT_END | end marker: both strobes with '=' and DONE
// S_FAULT    | sticky error, waits for RST
//
// Strobes are decoded in the same cycle as the emission decision so that a
// strobe is never high in a cycle where DS_BUSY is high. Output data shows
// the next-state value of the hold registers, so it is valid during the
// strobe and stays stable until the next one.
module infix_to_postfix #(
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       IN_CHAR,
    input  logic             IN_STB,
    output logic             IN_RDY,
    output logic [7:0]       INPUT_NUMBER,
    output logic             NUMBER_STB,
    output logic [7:0]       INPUT_SIGN,
    output logic             SIGN_STB,
    input  logic             DS_BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [LVL_W-1:0] OP_LEVEL
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    localparam logic [7:0] C_PLUS  = 8'h2B;
    localparam logic [7:0] C_MINUS = 8'h2D;
    localparam logic [7:0] C_MUL   = 8'h2A;
    localparam logic [7:0] C_DIV   = 8'h2F;
    localparam logic [7:0] C_LP    = 8'h28;
    localparam logic [7:0] C_RP    = 8'h29;
    localparam logic [7:0] C_EQ    = 8'h3D;
    localparam logic [7:0] C_SP    = 8'h20;

    typedef enum logic [2:0] {
        S_ACCEPT, S_EMIT_NUM, S_POP_OP, S_PUSH_OP,
        S_CLOSE, S_DRAIN, S_EMIT_END, S_FAULT
    } state_e;

    function automatic logic is_op(input logic [7:0] c);
        return (c == C_PLUS) || (c == C_MINUS) || (c == C_MUL) || (c == C_DIV);
    endfunction

    function automatic logic [1:0] prec(input logic [7:0] c);
        return ((c == C_MUL) || (c == C_DIV)) ? 2'd2 : 2'd1;
    endfunction

    function automatic state_e dispatch(input logic [7:0] c);
        case (c)
            C_LP:    return S_PUSH_OP;
            C_RP:    return S_CLOSE;
            C_EQ:    return S_DRAIN;
            default: return S_POP_OP;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic             have_num_q, have_num_d;
    logic [7:0]       tok_q, tok_d;
    logic [LVL_W-1:0] sp_q, sp_d;
    logic [7:0]       num_hold_q, num_hold_d;
    logic [7:0]       sign_hold_q, sign_hold_d;
    logic             stb_prev_q;
    logic [7:0]       stack_q [DEPTH];

    logic             push_we;
    logic             fire_num;
    logic             fire_sign;
    logic             can_emit;
    logic             is_digit;
    logic             is_tok;
    logic [7:0]       acc_next;
    logic [LVL_W-1:0] sp_m1;
    logic [7:0]       top_c;

    assign can_emit = !DS_BUSY && !stb_prev_q;
    assign is_digit = (IN_CHAR >= 8'h30) && (IN_CHAR <= 8'h39);
    assign is_tok   = is_op(IN_CHAR) || (IN_CHAR == C_LP) || (IN_CHAR == C_RP) || (IN_CHAR == C_EQ);
    // acc*10 + digit, truncated to 8 bits
    assign acc_next = {acc_q[4:0], 3'b000} + {acc_q[6:0], 1'b0} + {4'b0000, IN_CHAR[3:0]};
    assign sp_m1    = sp_q - LVL_ONE;
    assign top_c    = stack_q[sp_m1[IDX_W-1:0]];

    // Next-state, stack control and emission decisions
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        have_num_d  = have_num_q;
        tok_d       = tok_q;
        sp_d        = sp_q;
        num_hold_d  = num_hold_q;
        sign_hold_d = sign_hold_q;
        push_we     = 1'b0;
        fire_num    = 1'b0;
        fire_sign   = 1'b0;
        case (state_q)
            S_ACCEPT: begin
                if (IN_STB) begin
                    if (is_digit) begin
                        acc_d      = acc_next;
                        have_num_d = 1'b1;
                    end else if (IN_CHAR == C_SP) begin
                        state_d = S_ACCEPT;
                    end else if (is_tok) begin
                        tok_d   = IN_CHAR;
                        state_d = have_num_q ? S_EMIT_NUM : dispatch(IN_CHAR);
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_EMIT_NUM: begin
                if (can_emit) begin
                    fire_num   = 1'b1;
                    num_hold_d = acc_q;
                    acc_d      = 8'd0;
                    have_num_d = 1'b0;
                    state_d    = dispatch(tok_q);
                end
            end
            S_POP_OP: begin
                if ((sp_q != '0) && is_op(top_c) && (prec(top_c) >= prec(tok_q))) begin
                    if (can_emit) begin
                        fire_sign   = 1'b1;
                        sign_hold_d = top_c;
                        sp_d        = sp_m1;
                    end
                end else begin
                    state_d = S_PUSH_OP;
                end
            end
            S_PUSH_OP: begin
                if (sp_q == LVL_FULL) begin
                    state_d = S_FAULT;
                end else begin
                    push_we = 1'b1;
                    sp_d    = sp_q + LVL_ONE;
                    state_d = S_ACCEPT;
                end
            end
            S_CLOSE: begin
                if (sp_q == '0) begin
                    state_d = S_FAULT;
                end else if (top_c == C_LP) begin
                    sp_d    = sp_m1;
                    state_d = S_ACCEPT;
                end else if (can_emit) begin
                    fire_sign   = 1'b1;
                    sign_hold_d = top_c;
                    sp_d        = sp_m1;
                end
            end
            S_DRAIN: begin
                if (sp_q == '0) begin
                    state_d = S_EMIT_END;
                end else if (top_c == C_LP) begin
                    state_d = S_FAULT;
                end else if (can_emit) begin
                    fire_sign   = 1'b1;
                    sign_hold_d = top_c;
                    sp_d        = sp_m1;
                end
            end
            S_EMIT_END: begin
                if (can_emit) begin
                    fire_num    = 1'b1;
                    fire_sign   = 1'b1;
                    num_hold_d  = 8'd0;
                    sign_hold_d = C_EQ;
                    state_d     = S_ACCEPT;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // State, datapath and operator stack registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_ACCEPT;
            acc_q       <= 8'd0;
            have_num_q  <= 1'b0;
            tok_q       <= 8'd0;
            sp_q        <= '0;
            num_hold_q  <= 8'd0;
            sign_hold_q <= 8'd0;
            stb_prev_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= 8'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            have_num_q  <= have_num_d;
            tok_q       <= tok_d;
            sp_q        <= sp_d;
            num_hold_q  <= num_hold_d;
            sign_hold_q <= sign_hold_d;
            stb_prev_q  <= fire_num || fire_sign;
            if (push_we) stack_q[sp_q[IDX_W-1:0]] <= tok_q;
        end
    end

    assign IN_RDY       = (state_q == S_ACCEPT) && !RST;
    assign NUMBER_STB   = fire_num;
    assign SIGN_STB     = fire_sign;
    assign DONE         = fire_num && fire_sign;
    assign INPUT_NUMBER = num_hold_d;
    assign INPUT_SIGN   = sign_hold_d;
    assign ERR          = (state_q == S_FAULT);
    assign OP_LEVEL     = sp_q;

endmodule

// File: tb/tb_infix_to_postfix.sv
// Bench for infix_to_postfix: a queue-based shunting-yard model predicts the
// token stream, error outcome and stack occupancy; a monitor checks every
// strobe against it along with the emission-spacing and data-hold rules.
module tb_infix_to_postfix;

    localparam int DEPTH = 16;
    localparam int LVL_W = 5;

    logic             CLK = 1'b0;
    logic             RST;
    logic [7:0]       IN_CHAR;
    logic             IN_STB;
    logic             IN_RDY;
    logic [7:0]       INPUT_NUMBER;
    logic             NUMBER_STB;
    logic [7:0]       INPUT_SIGN;
    logic             SIGN_STB;
    logic             DS_BUSY = 1'b0;
    logic             DONE;
    logic             ERR;
    logic [LVL_W-1:0] OP_LEVEL;

    infix_to_postfix #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .CLK(CLK), .RST(RST), .IN_CHAR(IN_CHAR), .IN_STB(IN_STB), .IN_RDY(IN_RDY),
        .INPUT_NUMBER(INPUT_NUMBER), .NUMBER_STB(NUMBER_STB),
        .INPUT_SIGN(INPUT_SIGN), .SIGN_STB(SIGN_STB), .DS_BUSY(DS_BUSY),
        .DONE(DONE), .ERR(ERR), .OP_LEVEL(OP_LEVEL)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // tokens: 0..255 operand, 256+ascii operator, 512 end marker
    logic [7:0] expr_q[$];
    int         m_tok[$];
    int         exp_q[$];
    bit         m_err;
    int         m_level, m_peak, m_nsend;
    string      m_str;
    int         op_peak;
    bit         busy_rand, busy_force;
    logic [7:0] ops [4] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
    logic [7:0] bad [4] = '{8'h23, 8'h29, 8'h28, 8'h61};

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    function automatic bit mis_op(input int c);
        return (c == 43) || (c == 45) || (c == 42) || (c == 47);
    endfunction

    function automatic int mprec(input int c);
        return ((c == 42) || (c == 47)) ? 2 : 1;
    endfunction

    task automatic set_expr(input string s);
        expr_q.delete();
        for (int i = 0; i < s.len(); i++) expr_q.push_back(s[i]);
    endtask

    // Reference shunting-yard over the character queue
    task automatic model_run();
        int st[$];
        int acc;
        bit have;
        acc = 0; have = 0;
        m_tok.delete(); m_err = 0; m_peak = 0; m_nsend = 0;
        for (int i = 0; i < expr_q.size(); i++) begin
            int c;
            c = int'(expr_q[i]);
            m_nsend = i + 1;
            if (c >= 48 && c <= 57) begin
                acc = (acc * 10 + c - 48) % 256;
                have = 1;
            end else if (c != 32) begin
                if (!(mis_op(c) || c == 40 || c == 41 || c == 61)) begin
                    m_err = 1; break;
                end
                if (have) begin m_tok.push_back(acc); acc = 0; have = 0; end
                if (mis_op(c)) begin
                    while (st.size() > 0 && mis_op(st[$]) && mprec(st[$]) >= mprec(c))
                        m_tok.push_back(256 + st.pop_back());
                    if (st.size() == DEPTH) begin m_err = 1; break; end
                    st.push_back(c);
                end else if (c == 40) begin
                    if (st.size() == DEPTH) begin m_err = 1; break; end
                    st.push_back(c);
                end else begin
                    while (st.size() > 0 && st[$] != 40) m_tok.push_back(256 + st.pop_back());
                    if (c == 41) begin
                        if (st.size() == 0) begin m_err = 1; break; end
                        void'(st.pop_back());
                    end else begin
                        if (st.size() > 0) begin m_err = 1; break; end
                        m_tok.push_back(512);
                    end
                end
                if (st.size() > m_peak) m_peak = st.size();
            end
        end
        m_level = st.size();
        m_str = "";
        foreach (m_tok[k]) begin
            if (m_tok[k] < 256)       m_str = {m_str, $sformatf("%0d ", m_tok[k])};
            else if (m_tok[k] < 512)  m_str = {m_str, $sformatf("%c ", m_tok[k] - 256)};
            else                      m_str = {m_str, "= "};
        end
    endtask

    // DS_BUSY: random back-pressure or a forced level
    always @(posedge CLK) begin
        #1;
        DS_BUSY = busy_rand ? ($urandom_range(0, 99) < 30) : busy_force;
    end

    // Monitor: every strobe against the model, plus spacing/hold rules
    bit         prev_stb = 0;
    logic [7:0] last_num = 0, last_sign = 0;
    always @(negedge CLK) begin
        if (RST) begin
            prev_stb = 0; last_num = 0; last_sign = 0;
        end else begin
            if (int'(OP_LEVEL) > op_peak) op_peak = int'(OP_LEVEL);
            if (NUMBER_STB || SIGN_STB) begin
                int tok;
                check("stb_while_busy", int'(DS_BUSY), 0);
                check("stb_back_to_back", int'(prev_stb), 0);
                check("done_with_end", int'(DONE), int'(NUMBER_STB && SIGN_STB));
                if (NUMBER_STB && SIGN_STB) begin
                    tok = 512;
                    check("end_number", int'(INPUT_NUMBER), 0);
                    check("end_sign", int'(INPUT_SIGN), 61);
                end else if (NUMBER_STB) tok = int'(INPUT_NUMBER);
                else tok = 256 + int'(INPUT_SIGN);
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL token: got %0d, expected no token (t=%0t)", tok, $time);
                end else begin
                    check("token", tok, exp_q.pop_front());
                end
                if (NUMBER_STB) last_num = INPUT_NUMBER;
                if (SIGN_STB)   last_sign = INPUT_SIGN;
            end else begin
                check("done_idle", int'(DONE), 0);
                check("hold_number", int'(INPUT_NUMBER), int'(last_num));
                check("hold_sign", int'(INPUT_SIGN), int'(last_sign));
            end
            prev_stb = NUMBER_STB || SIGN_STB;
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        #2 RST = 1;
        exp_q.delete();
        repeat (2) @(negedge CLK);
        #2 RST = 0;
    endtask

    task automatic start_expr();
        model_run();
        exp_q = m_tok;
        op_peak = 0;
    endtask

    task automatic send_chars();
        for (int i = 0; i < m_nsend; i++) begin
            int w;
            @(negedge CLK);
            IN_CHAR = expr_q[i];
            IN_STB  = 1;
            w = 0;
            while (!IN_RDY && w < 3000) begin @(negedge CLK); w++; end
            check("char_accept_timeout", int'(w < 3000), 1);
            if (w >= 3000) break;
            @(posedge CLK);
        end
        @(negedge CLK);
        IN_STB = 0;
    endtask

    task automatic finish_expr();
        int w;
        w = 0;
        if (m_err) begin
            while (!ERR && w < 3000) begin @(negedge CLK); w++; end
            check("err_set", int'(ERR), 1);
            repeat (3) @(negedge CLK);
            check("err_hold", int'(ERR), 1);
            check("fault_rdy", int'(IN_RDY), 0);
            check("fault_level", int'(OP_LEVEL), m_level);
        end else begin
            while (!(exp_q.size() == 0 && IN_RDY) && w < 3000) begin @(negedge CLK); w++; end
            check("expr_timeout", int'(w < 3000), 1);
            check("err_clear", int'(ERR), 0);
            check("level_end", int'(OP_LEVEL), m_level);
        end
        check("tokens_left", exp_q.size(), 0);
        check("peak_level", op_peak, m_peak);
    endtask

    task automatic run_expr(input string s);
        set_expr(s);
        start_expr();
        send_chars();
        finish_expr();
    endtask

    task automatic gen_expr();
        int open, terms, idx;
        expr_q.delete();
        open = 0;
        terms = $urandom_range(1, 5);
        for (int t = 0; t < terms; t++) begin
            if ($urandom_range(0, 3) == 0) expr_q.push_back(8'h20);
            if (open < 3 && $urandom_range(0, 3) == 0) begin expr_q.push_back(8'h28); open++; end
            for (int d = 0; d < $urandom_range(1, 3); d++)
                expr_q.push_back(8'(48 + $urandom_range(0, 9)));
            if (open > 0 && $urandom_range(0, 2) == 0) begin expr_q.push_back(8'h29); open--; end
            if (t < terms - 1) expr_q.push_back(ops[$urandom_range(0, 3)]);
        end
        while (open > 0) begin expr_q.push_back(8'h29); open--; end
        expr_q.push_back(8'h3D);
        if ($urandom_range(0, 7) == 0 && expr_q.size() > 1) begin
            idx = $urandom_range(0, expr_q.size() - 2);
            expr_q[idx] = bad[$urandom_range(0, 3)];
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        int w;
        RST = 1; IN_STB = 0; IN_CHAR = 0; busy_rand = 0; busy_force = 0;
        #1;
        check("rst_number_stb", int'(NUMBER_STB), 0);
        check("rst_sign_stb", int'(SIGN_STB), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_err", int'(ERR), 0);
        check("rst_number", int'(INPUT_NUMBER), 0);
        check("rst_sign", int'(INPUT_SIGN), 0);
        check("rst_level", int'(OP_LEVEL), 0);
        repeat (3) @(negedge CLK);
        #2 RST = 0;
        #1 check("rst_rdy", int'(IN_RDY), 1);

        // Literal expectations that pin the model itself
        set_expr("3+4=");      model_run(); check_str("pin_3+4", m_str, "3 4 + = ");
        set_expr("2+3*4=");    model_run(); check_str("pin_prec", m_str, "2 3 4 * + = ");
        set_expr("8-2-1=");    model_run(); check_str("pin_left_assoc", m_str, "8 2 - 1 - = ");
        set_expr("12*(3-1)="); model_run(); check_str("pin_paren", m_str, "12 3 1 - * = ");
        check("pin_paren_peak", m_peak, 3);
        set_expr("300=");      model_run(); check_str("pin_mod256", m_str, "44 = ");
        set_expr("=");         model_run(); check_str("pin_empty", m_str, "= ");
        set_expr("(3+4=");     model_run(); check_str("pin_unclosed", m_str, "3 4 + ");
        check("pin_unclosed_err", int'(m_err), 1);
        set_expr("3)");        model_run(); check("pin_close_err", int'(m_err), 1);
        set_expr("3#");        model_run(); check("pin_bad_char_err", int'(m_err), 1);

        // Directed expressions, no back-pressure
        run_expr("3+4=");
        run_expr("2+3*4=");
        run_expr("8-2-1=");
        run_expr("12*(3-1)=");
        check("dut_paren_peak", op_peak, 3);
        run_expr("300=");
        run_expr("=");
        run_expr(" 7 / ( 2 ) - 1 * 9 =");

        // Back-pressure: DS_BUSY high for 10 cycles after the first strobe
        do_reset();
        set_expr("3+4=");
        start_expr();
        fork
            send_chars();
            begin
                w = 0;
                while (!(NUMBER_STB || SIGN_STB) && w < 200) begin @(negedge CLK); w++; end
                check("stall_first_strobe", int'(NUMBER_STB), 1);
                busy_force = 1;
                repeat (10) begin
                    @(negedge CLK);
                    check("stall_quiet", int'(NUMBER_STB || SIGN_STB), 0);
                end
                check("stall_rdy_low", int'(IN_RDY), 0);
                busy_force = 0;
                @(negedge CLK);
                check("resume_strobe", int'(NUMBER_STB), 1);
                check("resume_value", int'(INPUT_NUMBER), 4);
            end
        join
        finish_expr();

        // Error cases, each from reset
        do_reset(); run_expr("3)");
        do_reset(); run_expr("(3+4=");
        do_reset(); run_expr("3#");
        do_reset();
        s = "";
        for (int i = 0; i <= DEPTH; i++) s = {s, "("};
        run_expr(s);
        check("overflow_level", int'(OP_LEVEL), DEPTH);

        // Reset in the same cycle as a NUMBER_STB
        do_reset();
        set_expr("12+");
        start_expr();
        send_chars();
        w = 0;
        while (!NUMBER_STB && w < 50) begin @(negedge CLK); w++; end
        check("rst_mid_strobe_seen", int'(NUMBER_STB), 1);
        #1 RST = 1;
        exp_q.delete();
        #1;
        check("rst_mid_strobe_drop", int'(NUMBER_STB), 0);
        check("rst_mid_number", int'(INPUT_NUMBER), 0);
        repeat (2) @(negedge CLK);
        #2 RST = 0;
        #1;
        check("rst_mid_err", int'(ERR), 0);
        check("rst_mid_level", int'(OP_LEVEL), 0);
        check("rst_mid_rdy", int'(IN_RDY), 1);
        run_expr("5=");

        // Randomised expressions with random back-pressure
        busy_rand = 1;
        for (int n = 0; n < 80; n++) begin
            gen_expr();
            start_expr();
            send_chars();
            finish_expr();
            if (m_err) do_reset();
        end
        busy_rand = 0;

        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
